// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester bus arbiter: output-register
// state encoding and the default payload width.
package arb_pkg;
  localparam int ARB_DEF_SIZE = 32;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;
endpackage

// File: rtl/yMux2.sv
// Two-way word multiplexer: z = a when c = 0, z = b when c = 1.
module yMux2 import arb_pkg::*; #(
  parameter int SIZE = ARB_DEF_SIZE
) (
  output logic [SIZE-1:0] z,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            c
);
  assign z = c ? b : a;
endmodule

// File: rtl/bus_arb2.sv
// Two-requester round-robin arbiter feeding a single registered output word,
// with per-requester grant counters.
module bus_arb2 import arb_pkg::*; #(
  parameter int SIZE = ARB_DEF_SIZE,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  input  logic [SIZE-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [SIZE-1:0] b_data,
  output logic            b_ready,
  output logic            out_valid,
  output logic [SIZE-1:0] out_data,
  output logic            out_src,
  input  logic            out_ready,
  output logic            sel,
  output logic [CNTW-1:0] a_cnt,
  output logic [CNTW-1:0] b_cnt
);
  arb_state_e      state_q, state_d;
  logic            pri_q, pri_d;
  logic [SIZE-1:0] data_q, data_d;
  logic            src_q, src_d;
  logic [CNTW-1:0] a_cnt_q, a_cnt_d;
  logic [CNTW-1:0] b_cnt_q, b_cnt_d;
  logic            load;
  logic [SIZE-1:0] mux_data;

  yMux2 #(.SIZE(SIZE)) u_mux (
    .z (mux_data),
    .a (a_data),
    .b (b_data),
    .c (sel)
  );

  // Readies are gated by rst_n so nothing is handed off while reset is held.
  always_comb begin
    load    = (state_q == ST_EMPTY) || out_ready;
    sel     = b_valid && (!a_valid || pri_q);
    a_ready = rst_n && load && a_valid && !sel;
    b_ready = rst_n && load && b_valid && sel;
  end

  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    data_d  = data_q;
    src_d   = src_q;
    a_cnt_d = a_cnt_q + {{(CNTW-1){1'b0}}, a_ready};
    b_cnt_d = b_cnt_q + {{(CNTW-1){1'b0}}, b_ready};
    if (load) begin
      if (a_valid || b_valid) begin
        state_d = ST_FULL;
        data_d  = mux_data;
        src_d   = sel;
        pri_d   = !sel;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      pri_q   <= 1'b0;
      data_q  <= '0;
      src_q   <= 1'b0;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      data_q  <= data_d;
      src_q   <= src_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign a_cnt     = a_cnt_q;
  assign b_cnt     = b_cnt_q;
endmodule

// File: tb/tb_bus_arb2.sv
// Randomized and directed bench for bus_arb2 with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_bus_arb2;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, out_ready;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, out_valid, out_src, sel;
  logic [31:0] out_data;
  logic [7:0]  a_cnt, b_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] d; logic s; } exp_t;
  exp_t exp_q[$];

  // Reference model state
  bit          m_full;
  bit          m_pri;
  logic [31:0] m_data;
  bit          m_src;
  int          m_acnt, m_bcnt;

  always #10 clk = ~clk;

  bus_arb2 #(.SIZE(32), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .sel(sel), .a_cnt(a_cnt), .b_cnt(b_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_pri = 0; m_data = '0; m_src = 0; m_acnt = 0; m_bcnt = 0;
    exp_q.delete();
  endtask

  // Drives one cycle of inputs just after a rising edge; they are captured at
  // the following rising edge, which the model predicts here.
  task automatic cycle(input bit av, input logic [31:0] ad, input bit bv,
                       input logic [31:0] bd, input bit ordy);
    bit load;
    int win;
    @(posedge clk); #1;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
    #1;
    chk("out_valid", out_valid, m_full);
    chk("a_cnt", a_cnt, m_acnt);
    chk("b_cnt", b_cnt, m_bcnt);
    if (m_full) begin
      chk("held_data", out_data, m_data);
      chk("held_src", out_src, m_src);
    end
    load = !m_full || ordy;
    win  = -1;
    if (load && av && bv) win = m_pri ? 1 : 0;
    else if (load && av)  win = 0;
    else if (load && bv)  win = 1;
    chk("a_ready", a_ready, win == 0);
    chk("b_ready", b_ready, win == 1);
    chk("sel", sel, (av && bv) ? m_pri : bv);
    if (win >= 0) begin
      m_full = 1;
      m_data = (win == 1) ? bd : ad;
      m_src  = (win == 1);
      m_pri  = (win == 0);
      if (win == 0) m_acnt = (m_acnt + 1) % 256;
      else          m_bcnt = (m_bcnt + 1) % 256;
      exp_q.push_back('{d: m_data, s: m_src});
    end else if (load) begin
      m_full = 0;
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #1;
    a_valid = 1; b_valid = 1; out_ready = 1;
    rst_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_b_cnt", b_cnt, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    a_valid = 0; b_valid = 0; out_ready = 0;
    model_reset();
    #1;
    rst_n = 1;
  endtask

  // Monitor: a word is consumed at the next rising edge whenever
  // out_valid && out_ready; compare it against the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected: got data %0h src %0b with no expected word", out_data, out_src);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_src", out_src, e.s);
      end
    end
  end

  initial begin
    rst_n = 0; a_valid = 0; b_valid = 0; out_ready = 0; a_data = '0; b_data = '0;
    model_reset();
    #35 rst_n = 1;

    // Reset asserted between edges after some traffic
    cycle(1, 32'h1234, 1, 32'h5678, 1);
    cycle(1, 32'h2345, 0, 0, 0);
    do_reset();

    // A-only traffic
    cycle(1, 32'h11, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("aonly_valid", out_valid, 1);
    chk("aonly_data", out_data, 32'h11);
    chk("aonly_src", out_src, 0);
    chk("aonly_cnt", a_cnt, 1);

    // Contention: alternation A, B, A, B
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 32'hAAAA, 1, 32'hBBBB, 1);
    cycle(0, 0, 0, 0, 1);
    chk("cont_a_cnt", a_cnt, 2);
    chk("cont_b_cnt", b_cnt, 2);

    // Backpressure while B waits
    cycle(1, 32'h5, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 32'hB0B0, 0);
      chk("bp_b_ready", b_ready, 0);
      chk("bp_data", out_data, 32'h5);
    end
    cycle(0, 0, 1, 32'hB0B0, 1);
    chk("bp_release_b_ready", b_ready, 1);
    cycle(0, 0, 0, 0, 1);

    // Counter wrap after 256 A grants
    do_reset();
    for (int i = 0; i < 256; i++) cycle(1, i, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("wrap_a_cnt", a_cnt, 0);

    // Mid-transfer reset with pri pointing at B
    cycle(1, 32'h77, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    do_reset();
    cycle(1, 32'hA1, 1, 32'hB1, 1);
    chk("post_reset_a_ready", a_ready, 1);
    cycle(0, 0, 0, 0, 1);
    chk("post_reset_src", out_src, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) < 60), $urandom, ($urandom_range(0, 99) < 60),
            $urandom, ($urandom_range(0, 99) < 70));
    end
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    @(negedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
